// File: rtl/pe_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_row_feeder
// Description : Transmit side of the PE-row write interface. Consumes a
//               valid/ready word stream and, per job, emits one ifmap-clear
//               pulse, fw*fw row-major weights, then nl ifmap planes with a
//               switch-lane marker at every inner plane boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_row_feeder #(
   parameter int DATA_WIDTH       = 16,
   parameter int MAX_FILTER_WIDTH = 11,
   parameter int DIM_W            = 10,
   parameter int LANE_W           = 4,
   parameter int LOG_MFW          = $clog2(MAX_FILTER_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic [LOG_MFW:0]      i_filter_width,
   input  logic [DIM_W-1:0]      i_ifmap_width,
   input  logic [DIM_W-1:0]      i_ifmap_height,
   input  logic [LANE_W-1:0]     i_num_lanes,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_weight_data,
   output logic                  o_weight_valid,
   output logic [LOG_MFW:0]      o_wr_w_row_ptr,
   output logic [LOG_MFW:0]      o_wr_w_col_ptr,
   output logic [DATA_WIDTH-1:0] o_ifmap_data,
   output logic                  o_ifmap_valid,
   output logic                  o_reset_ifmap,
   output logic                  o_switch_lane,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_cfg_err
);

   localparam int              PW    = LOG_MFW + 1;
   localparam int              CW    = 2 * DIM_W;
   localparam logic [PW-1:0]   C_MFW = PW'(MAX_FILTER_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_LOAD_W = 3'd2,
      S_LOAD_I = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                r_state;
   logic [PW-1:0]         r_fw;
   logic [CW-1:0]         r_lane_size;
   logic [LANE_W-1:0]     r_nl;
   logic [PW-1:0]         r_row;
   logic [PW-1:0]         r_col;
   logic [CW-1:0]         r_pix;
   logic [LANE_W-1:0]     r_lane;

   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_weight_data;
   logic                  r_weight_valid;
   logic [PW-1:0]         r_row_out;
   logic [PW-1:0]         r_col_out;
   logic [DATA_WIDTH-1:0] r_ifmap_data;
   logic                  r_ifmap_valid;
   logic                  r_reset_ifmap;
   logic                  r_switch_lane;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_cfg_err;

   logic                  w_cfg_ok;
   logic                  w_xfer;
   logic [CW-1:0]         w_lane_size;

   // A job is only accepted when every dimension is non-zero and fw fits the row.
   assign w_cfg_ok    = (i_filter_width != '0) && (i_filter_width <= C_MFW) &&
                        (i_ifmap_width != '0) && (i_ifmap_height != '0) &&
                        (i_num_lanes != '0);
   // Words per lane are fixed for the whole job, so the product is latched at start.
   assign w_lane_size = CW'(i_ifmap_width) * CW'(i_ifmap_height);
   assign w_xfer      = i_valid & r_ready;

   assign o_ready        = r_ready;
   assign o_weight_data  = r_weight_data;
   assign o_weight_valid = r_weight_valid;
   assign o_wr_w_row_ptr = r_row_out;
   assign o_wr_w_col_ptr = r_col_out;
   assign o_ifmap_data   = r_ifmap_data;
   assign o_ifmap_valid  = r_ifmap_valid;
   assign o_reset_ifmap  = r_reset_ifmap;
   assign o_switch_lane  = r_switch_lane;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_cfg_err      = r_cfg_err;

   // Job sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_fw           <= '0;
         r_lane_size    <= '0;
         r_nl           <= '0;
         r_row          <= '0;
         r_col          <= '0;
         r_pix          <= '0;
         r_lane         <= '0;
         r_ready        <= 1'b0;
         r_weight_data  <= '0;
         r_weight_valid <= 1'b0;
         r_row_out      <= '0;
         r_col_out      <= '0;
         r_ifmap_data   <= '0;
         r_ifmap_valid  <= 1'b0;
         r_reset_ifmap  <= 1'b0;
         r_switch_lane  <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_cfg_err      <= 1'b0;
      end else begin
         // Strobes and pulses are single-cycle unless re-asserted below.
         r_weight_valid <= 1'b0;
         r_ifmap_valid  <= 1'b0;
         r_reset_ifmap  <= 1'b0;
         r_switch_lane  <= 1'b0;
         r_done         <= 1'b0;
         r_cfg_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Busy falls here, together with the done pulse of the previous job.
               r_busy <= 1'b0;
               if (i_start) begin
                  if (w_cfg_ok) begin
                     r_fw        <= i_filter_width;
                     r_lane_size <= w_lane_size;
                     r_nl        <= i_num_lanes;
                     r_row       <= '0;
                     r_col       <= '0;
                     r_pix       <= '0;
                     r_lane      <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= S_CLR;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            S_CLR: begin
               // Ready rises with the clear pulse, so it tracks the load states exactly.
               r_reset_ifmap <= 1'b1;
               r_ready       <= 1'b1;
               r_state       <= S_LOAD_W;
            end
            S_LOAD_W: begin
               if (w_xfer) begin
                  r_weight_data  <= i_data;
                  r_weight_valid <= 1'b1;
                  r_row_out      <= r_row;
                  r_col_out      <= r_col;
                  if (r_col == r_fw - 1'b1) begin
                     r_col <= '0;
                     if (r_row == r_fw - 1'b1) begin
                        r_row   <= '0;
                        r_state <= S_LOAD_I;
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            S_LOAD_I: begin
               if (w_xfer) begin
                  r_ifmap_data  <= i_data;
                  r_ifmap_valid <= 1'b1;
                  if (r_pix == r_lane_size - 1'b1) begin
                     r_pix <= '0;
                     if (r_lane == r_nl - 1'b1) begin
                        r_ready <= 1'b0;
                        r_state <= S_DONE;
                     end else begin
                        r_lane        <= r_lane + 1'b1;
                        r_switch_lane <= 1'b1;
                     end
                  end else begin
                     r_pix <= r_pix + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_row_feeder
// Description : Table of job configurations (legal and illegal) plus random
//               jobs, each checked against an ordered model of the expected
//               weight/ifmap output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_row_feeder;

   logic        clk;
   logic        reset;
   logic        i_start;
   logic [4:0]  i_filter_width;
   logic [9:0]  i_ifmap_width;
   logic [9:0]  i_ifmap_height;
   logic [3:0]  i_num_lanes;
   logic [15:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_weight_data;
   logic        o_weight_valid;
   logic [4:0]  o_wr_w_row_ptr;
   logic [4:0]  o_wr_w_col_ptr;
   logic [15:0] o_ifmap_data;
   logic        o_ifmap_valid;
   logic        o_reset_ifmap;
   logic        o_switch_lane;
   logic        o_busy;
   logic        o_done;
   logic        o_cfg_err;

   int n_vec = 0;
   int n_bad = 0;

   pe_row_feeder dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (i_start),
      .i_filter_width (i_filter_width),
      .i_ifmap_width  (i_ifmap_width),
      .i_ifmap_height (i_ifmap_height),
      .i_num_lanes    (i_num_lanes),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .o_weight_data  (o_weight_data),
      .o_weight_valid (o_weight_valid),
      .o_wr_w_row_ptr (o_wr_w_row_ptr),
      .o_wr_w_col_ptr (o_wr_w_col_ptr),
      .o_ifmap_data   (o_ifmap_data),
      .o_ifmap_valid  (o_ifmap_valid),
      .o_reset_ifmap  (o_reset_ifmap),
      .o_switch_lane  (o_switch_lane),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_cfg_err      (o_cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int fw;
      int iw;
      int ih;
      int nl;
      int err;     // 1 = start must be rejected
      int vmode;   // 0 valid always, 1 toggled, 2 random
      int glitch;  // 1 = extra start pulse during weight load
      int abort;   // >0 = reset after this many ifmap words
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic all_zero(input string name);
      chk(name, {o_ready, o_weight_data, o_weight_valid, o_wr_w_row_ptr, o_wr_w_col_ptr,
                 o_ifmap_data, o_ifmap_valid, o_reset_ifmap, o_switch_lane, o_busy,
                 o_done, o_cfg_err}, 64'd0);
   endtask

   task automatic next_valid(input int vmode);
      if (vmode == 0)      i_valid = 1'b1;
      else if (vmode == 1) i_valid = ~i_valid;
      else                 i_valid = 1'($urandom_range(0, 1));
   endtask

   // Illegal configuration: one error pulse, nothing else moves.
   task automatic bad_start(input int fw, input int iw, input int ih, input int nl);
      i_filter_width = 5'(fw);
      i_ifmap_width  = 10'(iw);
      i_ifmap_height = 10'(ih);
      i_num_lanes    = 4'(nl);
      i_start        = 1'b1;
      i_valid        = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("cfg_err_pulse", o_cfg_err, 1);
      chk("cfg_err_busy", o_busy, 0);
      chk("cfg_err_quiet", {o_ready, o_weight_valid, o_ifmap_valid, o_reset_ifmap, o_done}, 0);
      @(posedge clk); #1;
      chk("cfg_err_single", o_cfg_err, 0);
      chk("cfg_err_idle", {o_busy, o_ready, o_weight_valid, o_ifmap_valid, o_reset_ifmap}, 0);
      i_valid = 1'b0;
   endtask

   // Legal job: expected stream is the word list split into fw*fw weights then ifmap words.
   task automatic run_job(input int fw, input int iw, input int ih, input int nl,
                          input int vmode, input int glitch, input int abort_at,
                          output int done_cyc);
      logic [15:0] words[$];
      int  nw, ni, widx, wcnt, icnt, resets, dones, budget, cyc;
      bit  xfer, aborted, sw_exp;
      nw = fw * fw;
      ni = nl * iw * ih;
      for (int k = 0; k < nw + ni; k++) words.push_back(16'($urandom));
      widx = 0; wcnt = 0; icnt = 0; resets = 0; dones = 0;
      done_cyc = -1; aborted = 1'b0;
      budget = 4 * (nw + ni) + 20;
      i_filter_width = 5'(fw);
      i_ifmap_width  = 10'(iw);
      i_ifmap_height = 10'(ih);
      i_num_lanes    = 4'(nl);
      i_start        = 1'b1;
      i_valid        = 1'b1;
      i_data         = words[0];
      for (cyc = 1; cyc <= budget; cyc++) begin
         xfer = i_valid && o_ready;
         @(posedge clk); #1;
         i_start = 1'b0;
         if (cyc == 1) begin
            // Config changes after acceptance must not matter.
            i_filter_width = 5'($urandom_range(0, 31));
            i_ifmap_width  = 10'($urandom_range(0, 1023));
            i_ifmap_height = 10'($urandom_range(0, 1023));
            i_num_lanes    = 4'($urandom_range(0, 15));
         end
         chk("strobe", {o_weight_valid, o_ifmap_valid},
             xfer ? ((wcnt < nw) ? 2'b10 : 2'b01) : 2'b00);
         if (xfer) widx++;
         if (o_reset_ifmap) begin
            chk("reset_ifmap_order", wcnt, 0);
            resets++;
         end
         if (o_weight_valid && wcnt < nw) begin
            chk("w_data", o_weight_data, words[wcnt]);
            chk("w_row", o_wr_w_row_ptr, wcnt / fw);
            chk("w_col", o_wr_w_col_ptr, wcnt % fw);
            wcnt++;
         end
         if (o_ifmap_valid && icnt < ni) begin
            sw_exp = ((icnt + 1) % (iw * ih) == 0) && (icnt + 1 < ni);
            chk("i_data", o_ifmap_data, words[nw + icnt]);
            chk("switch_lane", o_switch_lane, sw_exp);
            icnt++;
         end else begin
            chk("switch_idle", o_switch_lane, 0);
         end
         chk("busy", o_busy, dones == 0);
         chk("cfg_err_job", o_cfg_err, 0);
         if (o_done) begin
            chk("done_wcnt", wcnt, nw);
            chk("done_icnt", icnt, ni);
            dones++;
            done_cyc = cyc;
         end
         if (abort_at > 0 && icnt == abort_at) begin
            reset   = 1'b1;
            i_valid = 1'b0;
            @(posedge clk); #1;
            all_zero("reset_mid_job");
            reset   = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (dones > 0 && !o_done) break;
         next_valid(vmode);
         i_data = (widx < nw + ni) ? words[widx] : 16'($urandom);
         if (glitch != 0 && cyc == 4) begin
            i_start        = 1'b1;
            i_filter_width = 5'(1);
            i_num_lanes    = 4'(1);
         end
      end
      i_valid = 1'b0;
      if (!aborted) begin
         chk("job_timeout", cyc <= budget, 1);
         chk("one_done", dones, 1);
         chk("one_reset_ifmap", resets, 1);
      end
   endtask

   vec_t vecs[12];
   int   dcyc;

   initial begin
      reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
      i_filter_width = '0; i_ifmap_width = '0; i_ifmap_height = '0; i_num_lanes = '0;

      //           fw  iw ih nl err vm gl ab
      vecs[0]  = '{ 3,  4, 4, 2, 0, 0, 0, 0};
      vecs[1]  = '{ 3,  4, 4, 2, 0, 1, 0, 0};
      vecs[2]  = '{ 0,  4, 4, 2, 1, 0, 0, 0};
      vecs[3]  = '{12,  4, 4, 2, 1, 0, 0, 0};
      vecs[4]  = '{ 3,  4, 4, 0, 1, 0, 0, 0};
      vecs[5]  = '{ 3,  0, 4, 2, 1, 0, 0, 0};
      vecs[6]  = '{ 3,  4, 0, 2, 1, 0, 0, 0};
      vecs[7]  = '{ 1,  1, 1, 1, 0, 0, 0, 0};
      vecs[8]  = '{ 3,  4, 4, 2, 0, 0, 0, 5};
      vecs[9]  = '{ 3,  4, 4, 2, 0, 0, 0, 0};
      vecs[10] = '{ 3,  4, 4, 2, 0, 0, 1, 0};
      vecs[11] = '{11,  2, 1, 1, 0, 2, 0, 0};

      repeat (3) @(posedge clk);
      #1;
      all_zero("reset_state");
      reset = 1'b0;
      @(posedge clk); #1;
      all_zero("idle_after_reset");

      foreach (vecs[i]) begin
         if (vecs[i].err != 0) begin
            bad_start(vecs[i].fw, vecs[i].iw, vecs[i].ih, vecs[i].nl);
         end else begin
            run_job(vecs[i].fw, vecs[i].iw, vecs[i].ih, vecs[i].nl,
                    vecs[i].vmode, vecs[i].glitch, vecs[i].abort, dcyc);
            // Minimal job: done appears in the sixth cycle counting the start cycle.
            if (vecs[i].fw == 1 && vecs[i].iw == 1 && vecs[i].ih == 1 &&
                vecs[i].nl == 1 && vecs[i].vmode == 0)
               chk("min_latency", dcyc, 5);
         end
         @(posedge clk); #1;
         chk("idle_between", {o_busy, o_ready}, 0);
      end

      for (int r = 0; r < 8; r++) begin
         run_job($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(1, 3), 2, 0, 0, dcyc);
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
